// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter, start + LSB-first data + optional parity + stop, prescaled bit timing.
// Define UART_TX_TWO_STOP_EN for two stop bits; the port list is the same in both builds.
module uart_tx_frame #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);
`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_CLKS = 2 * CLKS_PER_BIT;
`else
    localparam int STOP_CLKS = CLKS_PER_BIT;
`endif
    localparam int CW = $clog2(2 * CLKS_PER_BIT + 1);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [BW-1:0]         bit_cnt, bit_cnt_n;
    logic [DATA_WIDTH-1:0] shift, shift_n;
    logic                  par, par_n, par_en, par_en_n, last, tx_n;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CW'(1);
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        par_n     = par;
        par_en_n  = par_en;
        last      = cnt == (state == STOP ? CW'(STOP_CLKS - 1) : CW'(CLKS_PER_BIT - 1));
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (Data_Valid) begin
                    state_n  = START;
                    shift_n  = P_DATA;
                    par_en_n = PAR_EN;
                    par_n    = PAR_TYP ? ~^P_DATA : ^P_DATA;
                end
            end
            START: if (last) begin
                state_n   = DATA;
                cnt_n     = '0;
                bit_cnt_n = '0;
            end
            DATA: if (last) begin
                cnt_n = '0;
                if (bit_cnt == BW'(DATA_WIDTH - 1))
                    state_n = par_en ? PARITY : STOP;
                else begin
                    bit_cnt_n = bit_cnt + BW'(1);
                    shift_n   = shift >> 1;
                end
            end
            PARITY: if (last) begin
                state_n = STOP;
                cnt_n   = '0;
            end
            STOP: if (last) begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: state_n = IDLE;
        endcase
        // Line level is decided from the next state so TX_OUT comes straight off a flop.
        tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : state_n == PARITY ? par_n : 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            par     <= 1'b0;
            par_en  <= 1'b0;
            TX_OUT  <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            par     <= par_n;
            par_en  <= par_en_n;
            TX_OUT  <= tx_n;
        end
    end

    assign Busy = state != IDLE;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: scoreboard bench for uart_tx_frame; expected frames are queued at request time
// and checked cycle by cycle against the line when Busy rises.
module tb_uart_tx_frame;
    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    typedef struct {
        logic [DW-1:0] d;
        logic          pe;
        logic          pt;
    } frame_t;

    logic          clk = 0, rst = 1, dv = 0, pe = 0, pt = 0;
    logic [DW-1:0] pd = '0;
    logic          tx, busy;
    frame_t        sb[$];
    int            n_cmp = 0, n_bad = 0;
    logic          expect_abort = 0;

    uart_tx_frame #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .CLK(clk), .RST(rst), .P_DATA(pd), .Data_Valid(dv),
        .PAR_EN(pe), .PAR_TYP(pt), .TX_OUT(tx), .Busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input frame_t f, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DW) return f.d[idx-1];
        if (idx == DW + 1 && f.pe) return f.pt ? ~^f.d : ^f.d;
        return 1'b1;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) check("idle_timeout", 32'(busy), 0);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic p_en, input logic p_typ, input logic push);
        wait_idle();
        pd = d;
        pe = p_en;
        pt = p_typ;
        dv = 1;
        if (push) sb.push_back('{d: d, pe: p_en, pt: p_typ});
        tick();
        check("accept_busy", 32'(busy), 1);
        dv = 0;
        pd = ~d;
        pe = ~p_en;
        pt = ~p_typ;
    endtask

    // Monitor: one frame per Busy rise, checking every cycle of the frame plus the idle cycle after it.
    initial begin
        frame_t f;
        int     len, n;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                if (expect_abort) begin
                    n = 0;
                    while (busy !== 1'b0 && n < 400) begin
                        @(negedge clk);
                        n++;
                    end
                    expect_abort = 0;
                end else if (sb.size() == 0) begin
                    check("unexpected_frame", 32'(busy), 0);
                end else begin
                    f   = sb.pop_front();
                    len = CPB * (1 + DW + int'(f.pe) + NSTOP);
                    for (int i = 0; i < len; i++) begin
                        if (i > 0) @(negedge clk);
                        check($sformatf("line_%02h_c%0d", f.d, i), 32'(tx), 32'(exp_bit(f, i / CPB)));
                        check($sformatf("busy_%02h_c%0d", f.d, i), 32'(busy), 1);
                    end
                    @(negedge clk);
                    check($sformatf("gap_busy_%02h", f.d), 32'(busy), 0);
                    check($sformatf("gap_line_%02h", f.d), 32'(tx), 1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_line", 32'(tx), 1);
            check("rst_busy", 32'(busy), 0);
        end
        rst = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle_line", 32'(tx), 1);
            check("idle_busy", 32'(busy), 0);
        end

        send(8'hA5, 0, 0, 1);
        send(8'hA5, 1, 0, 1);
        send(8'hA5, 1, 1, 1);
        send(8'h07, 1, 0, 1);
        send(8'h55, 0, 0, 1);

        // Back-to-back with Data_Valid held: data change mid-frame must not leak into frame one.
        wait_idle();
        pd = 8'h3C;
        pe = 0;
        pt = 0;
        dv = 1;
        sb.push_back('{d: 8'h3C, pe: 1'b0, pt: 1'b0});
        sb.push_back('{d: 8'hC3, pe: 1'b0, pt: 1'b0});
        tick();
        repeat (20) tick();
        pd = 8'hC3;
        wait_idle();
        tick();
        check("b2b_accept", 32'(busy), 1);
        dv = 0;
        pd = 8'hFF;
        pe = 1;

        // Abort during data bit 3 of 0xFF.
        wait_idle();
        tick();
        expect_abort = 1;
        send(8'hFF, 0, 0, 0);
        repeat (CPB * 4 + 1) tick();
        check("pre_rst_line", 32'(tx), 1);
        rst = 1;
        tick();
        check("abort_line", 32'(tx), 1);
        check("abort_busy", 32'(busy), 0);
        rst = 0;
        repeat (3) tick();
        check("abort_done", 32'(expect_abort), 0);
        send(8'h00, 0, 0, 1);

        for (int i = 0; i < 4; i++)
            send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);

        wait_idle();
        repeat (4) tick();
        check("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
